// File: rtl/alu_serial_seq_if.sv
// Host-side handshake and result bundle for the bit-serial ALU sequencer.
// master = requester, slave = sequencer.
interface alu_serial_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [2:0]       cmd;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ofl;

    modport master (
        output start, cmd, a, b,
        input  ready, done, err, result, cout, ofl
    );

    modport slave (
        input  start, cmd, a, b,
        output ready, done, err, result, cout, ofl
    );
endinterface

// File: rtl/alu_serial_seq.sv
// Bit-serial WIDTH-bit ALU sequencer driving one external 1-bit slice,
// LSB first, with carry threaded between bits.
module alu_serial_seq #(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    alu_serial_seq_if.slave bus,
    output logic           sl_a,
    output logic           sl_b,
    output logic           sl_cin,
    output logic [1:0]     sl_op,
    output logic           sl_inva,
    output logic           sl_invb,
    input  logic           sl_out,
    input  logic           sl_cout
);

    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        C_ADD  = 3'd0,
        C_SUB  = 3'd1,
        C_NAND = 3'd2,
        C_OR   = 3'd3,
        C_XOR  = 3'd4,
        C_RSUB = 3'd5
    } cmd_t;

    state_t           state_q, state_d;
    cmd_t             cmd_q, cmd_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ofl_q, ofl_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             illegal;
    logic             is_arith;
    logic             last;

    assign illegal  = (bus.cmd[2:1] == 2'b11);
    assign is_arith = (cmd_q == C_ADD) || (cmd_q == C_SUB) || (cmd_q == C_RSUB);
    assign last     = (idx_q == IW'(WIDTH - 1));

    assign bus.ready  = ready_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.ofl    = ofl_q;

    // Slice stimulus is live only in RUN; everything else parks at 0.
    always_comb begin
        sl_a    = 1'b0;
        sl_b    = 1'b0;
        sl_cin  = 1'b0;
        sl_op   = 2'b00;
        sl_inva = 1'b0;
        sl_invb = 1'b0;
        if (state_q == S_RUN) begin
            sl_a   = a_q[idx_q];
            sl_b   = b_q[idx_q];
            sl_cin = carry_q;
            unique case (cmd_q)
                C_ADD:   sl_op = 2'b00;
                C_SUB:   sl_invb = 1'b1;
                C_RSUB:  sl_inva = 1'b1;
                C_NAND:  sl_op = 2'b01;
                C_OR:    sl_op = 2'b10;
                C_XOR:   sl_op = 2'b11;
                default: sl_op = 2'b00;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ofl_d    = ofl_q;
        ready_d  = ready_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (illegal) begin
                        err_d = 1'b1;
                    end else begin
                        cmd_d    = cmd_t'(bus.cmd);
                        a_d      = bus.a;
                        b_d      = bus.b;
                        result_d = '0;
                        carry_d  = (bus.cmd == C_SUB) || (bus.cmd == C_RSUB);
                        idx_d    = '0;
                        ready_d  = 1'b0;
                        state_d  = S_RUN;
                    end
                end
            end
            S_RUN: begin
                result_d[idx_q] = sl_out;
                carry_d         = sl_cout;
                if (last) begin
                    // Overflow = carry into MSB xor carry out of MSB.
                    cout_d  = is_arith & sl_cout;
                    ofl_d   = is_arith & (carry_q ^ sl_cout);
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_DONE: begin
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cmd_q    <= C_ADD;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ofl_q    <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ofl_q    <= ofl_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed bench for alu_serial_seq with a behavioural 1-bit slice model.
module tb_alu_serial_seq;

    localparam int W = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sl_a, sl_b, sl_cin, sl_inva, sl_invb;
    logic [1:0] sl_op;
    logic       sl_out, sl_cout;
    logic       ea, eb;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    alu_serial_seq_if #(.WIDTH(W)) bus ();

    alu_serial_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .sl_a    (sl_a),
        .sl_b    (sl_b),
        .sl_cin  (sl_cin),
        .sl_op   (sl_op),
        .sl_inva (sl_inva),
        .sl_invb (sl_invb),
        .sl_out  (sl_out),
        .sl_cout (sl_cout)
    );

    // Reference slice: optional input inversion, then op select.
    always_comb begin
        ea      = sl_a ^ sl_inva;
        eb      = sl_b ^ sl_invb;
        sl_cout = (ea & eb) | (ea & sl_cin) | (eb & sl_cin);
        case (sl_op)
            2'b00:   sl_out = ea ^ eb ^ sl_cin;
            2'b01:   sl_out = ~(ea & eb);
            2'b10:   sl_out = ea | eb;
            default: sl_out = ea ^ eb;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full operation from IDLE: checks per-cycle slice drive and timing.
    task automatic do_op(input string nm, input logic [2:0] c,
                         input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [1:0] eop, input logic einva,
                         input logic einvb, input logic [W-1:0] er,
                         input logic ec, input logic eo);
        logic [W-1:0] oa, ob, oia, oib, rdy, dn;
        logic [2*W-1:0] oop, xop;
        bus.start = 1'b1;
        bus.cmd   = c;
        bus.a     = x;
        bus.b     = y;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < W; i++) begin
            oa[i]  = sl_a;
            ob[i]  = sl_b;
            oia[i] = sl_inva;
            oib[i] = sl_invb;
            oop[2*i +: 2] = sl_op;
            xop[2*i +: 2] = eop;
            rdy[i] = bus.ready;
            dn[i]  = bus.done;
            tick();
        end
        chk({nm, " sl_a"}, 32'(oa), 32'(x));
        chk({nm, " sl_b"}, 32'(ob), 32'(y));
        chk({nm, " sl_op"}, oop, xop);
        chk({nm, " inv"}, {oia, oib}, {{W{einva}}, {W{einvb}}});
        chk({nm, " ready/done run"}, {rdy, dn}, 32'h0);
        chk({nm, " done"}, 32'(bus.done), 32'h1);
        chk({nm, " ready in done"}, 32'(bus.ready), 32'h0);
        chk({nm, " result"}, 32'(bus.result), 32'(er));
        chk({nm, " cout/ofl"}, {bus.cout, bus.ofl}, {ec, eo});
        tick();
        chk({nm, " ready after"}, {bus.ready, bus.done}, 2'b10);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.cmd   = 3'd0;
        bus.a     = '0;
        bus.b     = '0;
        tick();
        tick();
        chk("reset outs", {bus.done, bus.err, bus.cout, bus.ofl},
            4'h0);
        chk("reset result", 32'(bus.result), 32'h0);
        chk("reset slice", {sl_a, sl_b, sl_cin, sl_op, sl_inva, sl_invb},
            7'h0);
        rst = 1'b1;
        tick();
        chk("ready after reset", 32'(bus.ready), 32'h1);

        do_op("add ovf", 3'd0, 16'h7FFF, 16'h0001, 2'b00, 1'b0, 1'b0,
              16'h8000, 1'b0, 1'b1);
        do_op("sub", 3'd1, 16'h0005, 16'h0007, 2'b00, 1'b0, 1'b1,
              16'hFFFE, 1'b0, 1'b0);
        do_op("rsub", 3'd5, 16'h0005, 16'h0007, 2'b00, 1'b1, 1'b0,
              16'h0002, 1'b1, 1'b0);
        do_op("xor", 3'd4, 16'hA5A5, 16'hFFFF, 2'b11, 1'b0, 1'b0,
              16'h5A5A, 1'b0, 1'b0);
        do_op("or", 3'd3, 16'hA5A5, 16'hFFFF, 2'b10, 1'b0, 1'b0,
              16'hFFFF, 1'b0, 1'b0);
        do_op("nand", 3'd2, 16'hA5A5, 16'hFFFF, 2'b01, 1'b0, 1'b0,
              16'h5A5A, 1'b0, 1'b0);
        do_op("add cout", 3'd0, 16'h8000, 16'h8000, 2'b00, 1'b0, 1'b0,
              16'h0000, 1'b1, 1'b1);

        // Start during RUN is dropped.
        begin
            int ndone = 0;
            int dcyc  = 0;
            bus.start = 1'b1;
            bus.cmd   = 3'd0;
            bus.a     = 16'h0001;
            bus.b     = 16'h0001;
            tick();
            bus.start = 1'b0;
            for (int cyc = 1; cyc <= 24; cyc++) begin
                if (cyc == 5) begin
                    bus.start = 1'b1;
                    bus.cmd   = 3'd1;
                    bus.a     = 16'h1234;
                    bus.b     = 16'h0001;
                end else begin
                    bus.start = 1'b0;
                end
                if (bus.done) begin
                    ndone++;
                    dcyc = cyc;
                end
                tick();
            end
            chk("ignore start ndone", 32'(ndone), 32'd1);
            chk("ignore start dcyc", 32'(dcyc), 32'd17);
            chk("ignore start result", 32'(bus.result), 32'h0002);
            chk("ignore start ready", 32'(bus.ready), 32'h1);
        end

        // Reset in the middle of an operation.
        begin
            int ndone = 0;
            bus.start = 1'b1;
            bus.cmd   = 3'd0;
            bus.a     = 16'hFFFF;
            bus.b     = 16'h0001;
            tick();
            bus.start = 1'b0;
            for (int cyc = 1; cyc < 8; cyc++) tick();
            chk("pre-reset sl_a", 32'(sl_a), 32'h1);
            rst = 1'b0;
            #1;
            chk("abort result", 32'(bus.result), 32'h0);
            chk("abort slice", {sl_a, sl_b, sl_cin, sl_op, sl_inva, sl_invb},
                7'h0);
            tick();
            tick();
            rst = 1'b1;
            for (int cyc = 0; cyc < 20; cyc++) begin
                if (bus.done) ndone++;
                tick();
            end
            chk("abort no done", 32'(ndone), 32'd0);
            chk("abort ready", 32'(bus.ready), 32'h1);
        end
        do_op("add fresh", 3'd0, 16'h0003, 16'h0004, 2'b00, 1'b0, 1'b0,
              16'h0007, 1'b0, 1'b0);

        // Illegal command.
        bus.start = 1'b1;
        bus.cmd   = 3'b111;
        bus.a     = 16'h1111;
        bus.b     = 16'h2222;
        tick();
        bus.start = 1'b0;
        chk("illegal err", {bus.err, bus.ready, bus.done}, 3'b110);
        chk("illegal result", 32'(bus.result), 32'h0007);
        chk("illegal no run", {sl_a, sl_b, sl_cin, sl_op}, 5'h0);
        tick();
        chk("illegal err clr", {bus.err, bus.ready, bus.done}, 3'b010);
        bus.start = 1'b1;
        bus.cmd   = 3'b110;
        tick();
        bus.start = 1'b0;
        chk("illegal 110 err", {bus.err, bus.ready}, 2'b11);
        chk("illegal 110 result", 32'(bus.result), 32'h0007);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/alu_serial_seq.md
Name: alu_serial_seq

Overview:
Sequencer that time-shares one external 1-bit ALU slice (alu_1b) to perform WIDTH-bit operations bit-serially, LSB first.
- Latches operands and a command on a start handshake.
- Drives the slice one bit per cycle and carries the slice carry-out between bits.
- Assembles the result word and reports carry-out, signed overflow and completion.
- Sits between the demo1 control logic and a single alu_1b instance.

Parameters:
WIDTH, 16, operand/result width in bits; also the number of RUN cycles (legal range 2..32).

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  request; accepted only in a cycle where ready=1
cmd  input  3  000 ADD, 001 SUB (a-b), 010 NAND, 011 OR, 100 XOR, 101 RSUB (b-a), 110/111 illegal
a  input  WIDTH  operand A, sampled on acceptance
b  input  WIDTH  operand B, sampled on acceptance
ready  output  1  high in IDLE
done  output  1  one-cycle pulse; result/cout/ofl valid from this cycle on
err  output  1  one-cycle pulse on acceptance of an illegal cmd
result  output  WIDTH  assembled result, held until next accepted start
cout  output  1  final carry (arith ops), 0 for logic ops
ofl  output  1  signed overflow (arith ops), 0 for logic ops
sl_a  output  1  slice A input
sl_b  output  1  slice B input
sl_cin  output  1  slice carry-in
sl_op  output  2  slice op: 00 add, 01 nand, 10 or, 11 xor
sl_invA  output  1  slice invert-A
sl_invB  output  1  slice invert-B
sl_out  input  1  slice result bit (combinational from sl_*)
sl_cout  input  1  slice carry-out (combinational from sl_*)

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, idx=0, carry=0.
  - result=0, cout=0, ofl=0, done=0, err=0.
  - All sl_* outputs=0; ready=1 once rst deasserts.
  - Reset mid-RUN aborts the operation; no done pulse follows.
- States IDLE, RUN, DONE:
  - IDLE: ready=1. On start=1 with a legal cmd:
    - latch a, b, cmd; clear result.
    - carry := 1 for SUB/RSUB, else 0; idx := 0.
    - go to RUN.
  - IDLE, start=1 with cmd 110/111: err=1 for the next cycle; state stays IDLE; result/cout/ofl unchanged.
  - RUN (WIDTH cycles):
    - sl_a=a_r[idx], sl_b=b_r[idx], sl_cin=carry.
    - sl_op and invert bits from the latched cmd:
      - ADD: 00, inv 0/0.
      - SUB: 00, invB=1.
      - RSUB: 00, invA=1.
      - NAND: 01. OR: 10. XOR: 11.
    - Each edge: result[idx] := sl_out, carry := sl_cout, idx := idx+1.
    - On the edge with idx=WIDTH-1, for arithmetic ops only:
      - cout := sl_cout.
      - ofl := carry XOR sl_cout, i.e. carry into MSB XOR carry out.
    - Same edge: go to DONE.
    - Logic ops: carry chain still runs, but cout and ofl are forced to 0.
  - DONE (one cycle): done=1, ready=0; next edge goes to IDLE.
- Latency: start accepted in cycle 0; RUN occupies cycles 1..WIDTH; done=1 in cycle WIDTH+1; ready=1 in cycle WIDTH+2.
- Outside RUN, all sl_* outputs are driven 0.
- start in RUN/DONE is ignored; it is not queued.
- a, b, cmd changing during RUN have no effect.
- idx is ceil(log2(WIDTH)) bits wide and never wraps during an operation.
- SUB/RSUB cout follows carry-out convention: 1 means no borrow.

Test Plan:
1. ADD, a=0x7FFF, b=0x0001, WIDTH=16 -> done in cycle 17; result=0x8000, cout=0, ofl=1; ready=0 in cycles 1..17, ready=1 in cycle 18.
2. SUB, a=0x0005, b=0x0007 -> result=0xFFFE, cout=0, ofl=0. RSUB with the same operands -> result=0x0002, cout=1, ofl=0.
3. Logic ops, a=0xA5A5, b=0xFFFF:
   - XOR -> 0x5A5A.
   - OR -> 0xFFFF.
   - NAND -> 0x5A5A.
   - cout=0 and ofl=0 for all three; per-cycle sl_op and sl_a/sl_b match the latched bits, LSB first.
4. ADD 0x0001+0x0001 started; in cycle 5 pulse start with SUB 0x1234, 0x0001 -> second start ignored; result=0x0002; exactly one done pulse.
5. Start ADD 0xFFFF+0x0001, drive rst=0 in cycle 8 -> outputs clear immediately (result=0, sl_*=0); no done pulse; after release, ready=1 and a fresh ADD 0x0003+0x0004 yields result=0x0007.
6. cmd=111, start=1 while prior result=0x0007 -> err pulse in cycle 1, no RUN, ready stays 1, result remains 0x0007, done stays 0.
